// File: rtl/cordic_nco_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_nco_scheduler
//
// Multi-channel NCO controller. One pipelined CORDIC sin/cos engine is
// shared among NCH channels. Each channel has a 32-bit phase accumulator, a
// frequency tuning word, a phase offset and an enable bit. On every sample
// tick the enabled channels are issued round-robin, one per cycle. A tag
// pipeline that matches the CORDIC latency labels each returning sin/cos pair
// with its channel number.
//
// Optional build macro: PHASE_DITHER_EN
//   When defined, a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1,
//   advancing on each issue) is added to the issued phase to whiten
//   phase-truncation spurs. Accumulators are not affected.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   tick_i             sample-period strobe (1 cycle)
//   cfg_we_i           config write strobe
//   cfg_chan_i         target channel
//   cfg_sel_i          00=FTW 01=phase offset 10=accumulator clear 11=enable
//   cfg_data_i         config write data
//   cor_valid_o        CORDIC input valid (registered)
//   cor_phase_o        CORDIC input phase, 2^32 = 2*pi, 0 when not valid
//   cor_valid_i        CORDIC output valid
//   cor_sin_i/cos_i    CORDIC outputs, signed
//   out_valid_o        tagged sample valid
//   out_chan_o         channel of the sample
//   out_sin_o/cos_o    signed sine/cosine
//   busy_o             scan in progress
//   overrun_o          sticky: tick arrived while busy
//   tag_err_o          sticky: CORDIC valid and tag valid disagreed
//   err_clr_i          clears both sticky flags (a coincident set wins)
// ---------------------------------------------------------------------------
module cordic_nco_scheduler #(
    parameter int NCH  = 4,
    parameter int CH_W = $clog2(NCH),
    parameter int LAT  = 18
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            tick_i,
    input  logic            cfg_we_i,
    input  logic [CH_W-1:0] cfg_chan_i,
    input  logic [1:0]      cfg_sel_i,
    input  logic [31:0]     cfg_data_i,
    output logic            cor_valid_o,
    output logic [31:0]     cor_phase_o,
    input  logic            cor_valid_i,
    input  logic [15:0]     cor_sin_i,
    input  logic [15:0]     cor_cos_i,
    output logic            out_valid_o,
    output logic [CH_W-1:0] out_chan_o,
    output logic [15:0]     out_sin_o,
    output logic [15:0]     out_cos_o,
    output logic            busy_o,
    output logic            overrun_o,
    output logic            tag_err_o,
    input  logic            err_clr_i
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CH_W-1:0] r_ptr;
    logic [NCH-1:0]  r_mask;
    logic [NCH-1:0]  r_en;
    logic [31:0]     r_acc  [NCH];
    logic [31:0]     r_ftw  [NCH];
    logic [31:0]     r_poff [NCH];

    logic            w_start;
    logic            w_issue;
    logic            w_tick_drop;
    logic [15:0]     w_dither;
    logic [31:0]     w_phase;

    logic            r_cor_valid;
    logic [31:0]     r_cor_phase;
    logic [CH_W-1:0] r_cor_chan;

    logic            r_tag_vld  [LAT];
    logic [CH_W-1:0] r_tag_chan [LAT];
    logic            w_tag_mis;

    logic                r_out_valid;
    logic [CH_W-1:0]     r_out_chan;
    logic signed [15:0]  r_out_sin;
    logic signed [15:0]  r_out_cos;
    logic                r_overrun;
    logic                r_tag_err;

    function automatic logic [31:0] f_phase(input logic [31:0] acc,
                                            input logic [31:0] poff,
                                            input logic [15:0] dith);
        return acc + poff + {16'h0000, dith};
    endfunction

`ifdef PHASE_DITHER_EN
    // Fibonacci form: feedback from taps 16,14,13,11 (bits 0,2,3,5 shifting right).
    function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [15:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_lfsr <= 16'hACE1;
        else if (w_issue) r_lfsr <= f_lfsr_next(r_lfsr);
    end

    assign w_dither = r_lfsr;
`else
    assign w_dither = 16'h0000;
`endif

    // ---- scan control: next state ----
    always_comb begin
        w_state_nx  = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_tick_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tick_i) begin
                    w_state_nx = S_SCAN;
                    w_start    = 1'b1;
                end
            end
            S_SCAN: begin
                w_issue     = r_mask[r_ptr];
                w_tick_drop = tick_i;
                if (r_ptr == CH_W'(NCH - 1)) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_phase = f_phase(r_acc[r_ptr], r_poff[r_ptr], w_dither);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_ptr  <= '0;
                r_mask <= r_en;
            end else if (r_state == S_SCAN) begin
                r_ptr  <= r_ptr + 1'b1;
            end
        end
    end

    // ---- channel state: config writes and accumulator advance ----
    // Non-blocking updates make a same-cycle write land after the issue reads
    // the old values; only the accumulator clear overrides the increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_acc[i]  <= '0;
                r_ftw[i]  <= '0;
                r_poff[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we_i && cfg_chan_i == CH_W'(i)) begin
                    if (cfg_sel_i == 2'b00) r_ftw[i]  <= cfg_data_i;
                    if (cfg_sel_i == 2'b01) r_poff[i] <= cfg_data_i;
                    if (cfg_sel_i == 2'b11) r_en[i]   <= cfg_data_i[0];
                end
                if (cfg_we_i && cfg_chan_i == CH_W'(i) && cfg_sel_i == 2'b10)
                    r_acc[i] <= '0;
                else if (w_issue && r_ptr == CH_W'(i))
                    r_acc[i] <= r_acc[i] + r_ftw[i];
            end
        end
    end

    // ---- issue register: phase to CORDIC ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cor_valid <= 1'b0;
            r_cor_phase <= '0;
            r_cor_chan  <= '0;
        end else begin
            r_cor_valid <= w_issue;
            r_cor_phase <= w_issue ? w_phase : 32'h0;
            r_cor_chan  <= r_ptr;
        end
    end

    // ---- tag pipeline: shadows the CORDIC so the tail lines up with cor_valid_i ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                r_tag_vld[i]  <= 1'b0;
                r_tag_chan[i] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= r_cor_valid;
            r_tag_chan[0] <= r_cor_chan;
            for (int i = 1; i < LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_chan[i] <= r_tag_chan[i-1];
            end
        end
    end

    assign w_tag_mis = cor_valid_i ^ r_tag_vld[LAT-1];

    // ---- output register and sticky error flags ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_sin   <= '0;
            r_out_cos   <= '0;
            r_overrun   <= 1'b0;
            r_tag_err   <= 1'b0;
        end else begin
            r_out_valid <= cor_valid_i;
            if (cor_valid_i) begin
                r_out_chan <= r_tag_chan[LAT-1];
                r_out_sin  <= signed'(cor_sin_i);
                r_out_cos  <= signed'(cor_cos_i);
            end
            r_overrun <= w_tick_drop | (r_overrun & ~err_clr_i);
            r_tag_err <= w_tag_mis   | (r_tag_err & ~err_clr_i);
        end
    end

    assign cor_valid_o = r_cor_valid;
    assign cor_phase_o = r_cor_phase;
    assign out_valid_o = r_out_valid;
    assign out_chan_o  = r_out_chan;
    assign out_sin_o   = r_out_sin;
    assign out_cos_o   = r_out_cos;
    assign busy_o      = (r_state == S_SCAN);
    assign overrun_o   = r_overrun;
    assign tag_err_o   = r_tag_err;

endmodule

// File: tb/tb_cordic_nco_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_nco_scheduler
//
// Self-checking bench for cordic_nco_scheduler (NCH=4, LAT=18). A behavioural
// CORDIC stand-in delays cor_valid_o/cor_phase_o by LAT cycles and returns
// sin = phase[31:16], cos = ~phase[31:16]. Stimulus pushes hand-computed
// expected phases and samples into queues; monitors pop and compare.
// ---------------------------------------------------------------------------
module tb_cordic_nco_scheduler;

    localparam int NCH  = 4;
    localparam int CH_W = 2;
    localparam int LAT  = 18;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic            cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_chan = '0;
    logic [1:0]      cfg_sel = '0;
    logic [31:0]     cfg_data = '0;
    logic            cor_valid_o;
    logic [31:0]     cor_phase_o;
    logic            cor_valid_i;
    logic [15:0]     cor_sin_i;
    logic [15:0]     cor_cos_i;
    logic            out_valid_o;
    logic [CH_W-1:0] out_chan_o;
    logic [15:0]     out_sin_o;
    logic [15:0]     out_cos_o;
    logic            busy_o;
    logic            overrun_o;
    logic            tag_err_o;
    logic            err_clr = 1'b0;

    logic            inj = 1'b0;
    logic [15:0]     inj_sin = '0;
    logic [15:0]     inj_cos = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic            chk_chan;
        logic [CH_W-1:0] chan;
        logic [15:0]     s;
        logic [15:0]     c;
    } out_exp_t;

    logic [31:0] iss_q [$];
    out_exp_t    out_q [$];
    int          lat_q [$];

    cordic_nco_scheduler #(.NCH(NCH), .CH_W(CH_W), .LAT(LAT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tick_i      (tick),
        .cfg_we_i    (cfg_we),
        .cfg_chan_i  (cfg_chan),
        .cfg_sel_i   (cfg_sel),
        .cfg_data_i  (cfg_data),
        .cor_valid_o (cor_valid_o),
        .cor_phase_o (cor_phase_o),
        .cor_valid_i (cor_valid_i),
        .cor_sin_i   (cor_sin_i),
        .cor_cos_i   (cor_cos_i),
        .out_valid_o (out_valid_o),
        .out_chan_o  (out_chan_o),
        .out_sin_o   (out_sin_o),
        .out_cos_o   (out_cos_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .tag_err_o   (tag_err_o),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CORDIC stand-in, reset by the same source as the DUT
    logic        pv [LAT];
    logic [31:0] pp [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pp[i] <= '0;
            end
        end else begin
            pv[0] <= cor_valid_o;
            pp[0] <= cor_phase_o;
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end
    logic [31:0] tail_ph;
    assign tail_ph     = pp[LAT-1];
    assign cor_valid_i = pv[LAT-1] | inj;
    assign cor_sin_i   = inj ? inj_sin : tail_ph[31:16];
    assign cor_cos_i   = inj ? inj_cos : ~tail_ph[31:16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // issue monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (cor_valid_o) begin
                if (iss_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got phase 0x%08h expected no issue", cor_phase_o);
                end else begin
                    check("issue_phase", cor_phase_o, iss_q.pop_front());
                end
                lat_q.push_back(cyc);
            end else begin
                check("idle_phase_zero", cor_phase_o, 32'h0);
            end
        end
    end

    // output monitor
    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            if (out_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got chan %0d expected no output", out_chan_o);
            end else begin
                out_exp_t e;
                e = out_q.pop_front();
                if (e.chk_chan) begin
                    check("out_chan", 32'(out_chan_o), 32'(e.chan));
                    if (lat_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL latency: got output with no issue recorded, expected %0d", LAT + 1);
                    end else begin
                        check("latency", 32'(cyc - lat_q.pop_front()), 32'(LAT + 1));
                    end
                end
                check("out_sin", 32'(out_sin_o), 32'(e.s));
                check("out_cos", 32'(out_cos_o), 32'(e.c));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [CH_W-1:0] ch, input logic [1:0] sel, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_chan = ch;
        cfg_sel  = sel;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic expect_issue(input logic [CH_W-1:0] ch, input logic [31:0] ph, input bit with_out);
        out_exp_t e;
        logic [15:0] hi;
        iss_q.push_back(ph);
        if (with_out) begin
            hi = ph[31:16];
            e.chk_chan = 1'b1;
            e.chan     = ch;
            e.s        = hi;
            e.c        = ~hi;
            out_q.push_back(e);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    // One tick plus 8 observed cycles. t2: cycle index of a second tick;
    // clr_k: cycle index at which an accumulator clear to clr_ch is driven.
    task automatic scan(input int t2, input int clr_k, input logic [CH_W-1:0] clr_ch,
                        output int nb, output int nv);
        nb = 0;
        nv = 0;
        tick = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            tick = (k == t2);
            if (k == clr_k) begin
                cfg_we   = 1'b1;
                cfg_chan = clr_ch;
                cfg_sel  = 2'b10;
                cfg_data = '0;
            end else begin
                cfg_we   = 1'b0;
            end
            if (busy_o)      nb++;
            if (cor_valid_o) nv++;
        end
        tick   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        repeat (LAT + 6) step();
        check({name, "_iss_q_empty"}, 32'(iss_q.size()), 32'd0);
        check({name, "_out_q_empty"}, 32'(out_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nv;
        logic [31:0] ph2 [5];
        ph2[0] = 32'h2000_0000; ph2[1] = 32'h6000_0000; ph2[2] = 32'hA000_0000;
        ph2[3] = 32'hE000_0000; ph2[4] = 32'h2000_0000;

        // reset state
        repeat (3) step();
        check("rst_cor_valid", 32'(cor_valid_o), 32'd0);
        check("rst_cor_phase", cor_phase_o, 32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_chan",  32'(out_chan_o), 32'd0);
        check("rst_out_sin",   32'(out_sin_o), 32'd0);
        check("rst_out_cos",   32'(out_cos_o), 32'd0);
        check("rst_busy",      32'(busy_o), 32'd0);
        check("rst_overrun",   32'(overrun_o), 32'd0);
        check("rst_tag_err",   32'(tag_err_o), 32'd0);
        rst_n = 1'b1;
        step();

        // reset in the middle of a scan
        for (int c = 0; c < NCH; c++) cfg(CH_W'(c), 2'b11, 32'd1);
        expect_issue(2'd0, 32'h0, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_cor_valid", 32'(cor_valid_o), 32'd0);
        check("midrst_cor_phase", cor_phase_o, 32'd0);
        check("midrst_busy",      32'(busy_o), 32'd0);
        check("midrst_out_valid", 32'(out_valid_o), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        drain_and_check("midrst");
        lat_q.delete();
        check("midrst_idle", 32'(busy_o), 32'd0);

        // all channels, distinct FTWs, two ticks
        cfg(2'd0, 2'b00, 32'h0100_0000);
        cfg(2'd1, 2'b00, 32'h0200_0000);
        cfg(2'd2, 2'b00, 32'h0400_0000);
        cfg(2'd3, 2'b00, 32'h0800_0000);
        for (int c = 0; c < NCH; c++) cfg(CH_W'(c), 2'b11, 32'd1);
        for (int c = 0; c < NCH; c++) expect_issue(CH_W'(c), 32'h0, 1'b1);
        scan(-1, -1, '0, nb, nv);
        check("t1_busy", 32'(nb), 32'd4);
        check("t1_issues", 32'(nv), 32'd4);
        expect_issue(2'd0, 32'h0100_0000, 1'b1);
        expect_issue(2'd1, 32'h0200_0000, 1'b1);
        expect_issue(2'd2, 32'h0400_0000, 1'b1);
        expect_issue(2'd3, 32'h0800_0000, 1'b1);
        scan(-1, -1, '0, nb, nv);
        check("t1b_busy", 32'(nb), 32'd4);
        check("t1b_issues", 32'(nv), 32'd4);
        drain_and_check("t1");

        // only ch2, with offset, wrap-around
        cfg(2'd0, 2'b11, 32'd0);
        cfg(2'd1, 2'b11, 32'd0);
        cfg(2'd3, 2'b11, 32'd0);
        cfg(2'd2, 2'b00, 32'h4000_0000);
        cfg(2'd2, 2'b01, 32'h2000_0000);
        cfg(2'd2, 2'b10, 32'h0);
        for (int t = 0; t < 5; t++) begin
            expect_issue(2'd2, ph2[t], 1'b1);
            scan(-1, -1, '0, nb, nv);
            check("t2_busy", 32'(nb), 32'd4);
            check("t2_issues", 32'(nv), 32'd1);
        end
        drain_and_check("t2");
        check("t2_overrun", 32'(overrun_o), 32'd0);
        check("t2_tag_err", 32'(tag_err_o), 32'd0);

        // tick two cycles into a scan
        expect_issue(2'd2, 32'h6000_0000, 1'b1);
        scan(2, -1, '0, nb, nv);
        check("ovr_busy", 32'(nb), 32'd4);
        check("ovr_issues", 32'(nv), 32'd1);
        check("ovr_set", 32'(overrun_o), 32'd1);
        pulse_clr();
        check("ovr_clr", 32'(overrun_o), 32'd0);

        // tick in the final scan cycle
        expect_issue(2'd2, 32'hA000_0000, 1'b1);
        scan(4, -1, '0, nb, nv);
        check("ovr_last_busy", 32'(nb), 32'd4);
        check("ovr_last_issues", 32'(nv), 32'd1);
        check("ovr_last_set", 32'(overrun_o), 32'd1);
        pulse_clr();
        check("ovr_last_clr", 32'(overrun_o), 32'd0);
        drain_and_check("ovr");

        // accumulator clear coincident with ch1 issue
        cfg(2'd2, 2'b11, 32'd0);
        cfg(2'd1, 2'b01, 32'h3000_0000);
        cfg(2'd1, 2'b00, 32'h1000_0000);
        cfg(2'd1, 2'b10, 32'h0);
        cfg(2'd1, 2'b11, 32'd1);
        expect_issue(2'd1, 32'h3000_0000, 1'b1);
        scan(-1, 2, 2'd1, nb, nv);
        check("clr_issues", 32'(nv), 32'd1);
        expect_issue(2'd1, 32'h3000_0000, 1'b1);
        scan(-1, -1, '0, nb, nv);
        expect_issue(2'd1, 32'h4000_0000, 1'b1);
        scan(-1, -1, '0, nb, nv);
        drain_and_check("clr");

        // CORDIC valid with empty tag pipeline
        check("inj_tag_err_pre", 32'(tag_err_o), 32'd0);
        begin
            out_exp_t e;
            e.chk_chan = 1'b0;
            e.chan     = '0;
            e.s        = 16'h1234;
            e.c        = 16'h8765;
            out_q.push_back(e);
        end
        inj_sin = 16'h1234;
        inj_cos = 16'h8765;
        inj = 1'b1;
        step();
        inj = 1'b0;
        check("inj_tag_err", 32'(tag_err_o), 32'd1);
        check("inj_out_valid", 32'(out_valid_o), 32'd1);
        step();
        check("inj_out_valid_drop", 32'(out_valid_o), 32'd0);
        pulse_clr();
        check("inj_tag_err_clr", 32'(tag_err_o), 32'd0);
        drain_and_check("inj");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
